// File: rtl/cv32e40s_lfsr.sv
// cv32e40s_lfsr
// Pseudo-random source for the dummy-instruction generator. It holds a single
// 32-bit Galois LFSR. Software can reseed it through a CSR write port. It
// advances once per issued or dummy instruction while rnddummy is enabled.
//
// Ports:
//   clk           core clock
//   rst           synchronous, active-high reset
//   enable_i      cpuctrl.rnddummy; gates shifting only
//   shift_i       advance request (instruction issued or dummy inserted)
//   seed_we_i     CSR write strobe to the seed register
//   seed_wdata_i  seed write data
//   cpuctrl_we_i  CSR write strobe to cpuctrl
//   lfsr_o        current LFSR state (xsecure_ctrl.lfsr0)
//   lockup_o      one-cycle pulse: all-zero state was replaced by the default seed
//   cntrst_o      one-cycle pulse: dummy counter must reset (xsecure_ctrl.cntrst)
module cv32e40s_lfsr #(
  parameter logic [31:0] LFSR_CFG_COEFFS   = 32'h8000_0057,
  parameter logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        shift_i,
  input  logic        seed_we_i,
  input  logic [31:0] seed_wdata_i,
  input  logic        cpuctrl_we_i,
  output logic [31:0] lfsr_o,
  output logic        lockup_o,
  output logic        cntrst_o
);

  // An all-zero default seed would make lockup recovery reload the lockup state.
  if (LFSR_DEFAULT_SEED == 32'h0) begin : g_bad_seed
    $error("cv32e40s_lfsr: LFSR_DEFAULT_SEED must be nonzero");
  end

  logic [31:0] r_lfsr;
  logic        r_lockup;
  logic        r_cntrst;

  logic [31:0] w_shifted;
  logic [31:0] w_candidate;
  logic [31:0] w_lfsr_next;
  logic        w_lockup;

  always_comb begin
    w_shifted   = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_CFG_COEFFS : '0);
    w_candidate = r_lfsr;
    if (seed_we_i) begin
      w_candidate = seed_wdata_i;
    end else if (enable_i && shift_i) begin
      w_candidate = w_shifted;
    end
    // The lockup check looks at the candidate and not at the current state.
    // This way a zero seed write and a zero state that is only being held
    // are both recovered in the same cycle.
    w_lockup    = (w_candidate == '0);
    w_lfsr_next = w_lockup ? LFSR_DEFAULT_SEED : w_candidate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= LFSR_DEFAULT_SEED;
      r_lockup <= 1'b0;
      r_cntrst <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_lockup <= w_lockup;
      r_cntrst <= seed_we_i | cpuctrl_we_i;
    end
  end

  assign lfsr_o   = r_lfsr;
  assign lockup_o = r_lockup;
  assign cntrst_o = r_cntrst;

endmodule

// File: tb/tb_cv32e40s_lfsr.sv
module tb_cv32e40s_lfsr;

  localparam logic [31:0] COEFFS = 32'h8000_0057;
  localparam logic [31:0] SEED0  = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        shift_i = 1'b0;
  logic        seed_we_i = 1'b0;
  logic [31:0] seed_wdata_i = '0;
  logic        cpuctrl_we_i = 1'b0;
  logic [31:0] lfsr_o;
  logic        lockup_o;
  logic        cntrst_o;

  cv32e40s_lfsr #(
    .LFSR_CFG_COEFFS  (COEFFS),
    .LFSR_DEFAULT_SEED(SEED0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .shift_i     (shift_i),
    .seed_we_i   (seed_we_i),
    .seed_wdata_i(seed_wdata_i),
    .cpuctrl_we_i(cpuctrl_we_i),
    .lfsr_o      (lfsr_o),
    .lockup_o    (lockup_o),
    .cntrst_o    (cntrst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        sh;
    logic        swe;
    logic [31:0] wdata;
    logic        cwe;
    logic [31:0] e_lfsr;
    logic        e_lock;
    logic        e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] lfsr;
    logic        lock;
    logic        cnt;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got lfsr %08h", tag, lfsr_o);
    end else begin
      e = sb_q.pop_front();
      check1({tag, ".lfsr"},   lfsr_o,            e.lfsr);
      check1({tag, ".lockup"}, {31'b0, lockup_o}, {31'b0, e.lock});
      check1({tag, ".cntrst"}, {31'b0, cntrst_o}, {31'b0, e.cnt});
    end
  endtask

  // Drive one cycle of stimulus at the negedge. Queue the expectation.
  // Compare at the following negedge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    rst = v.rst; enable_i = v.en; shift_i = v.sh;
    seed_we_i = v.swe; seed_wdata_i = v.wdata; cpuctrl_we_i = v.cwe;
    e.lfsr = v.e_lfsr; e.lock = v.e_lock; e.cnt = v.e_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare_out(tag);
  endtask

  function automatic logic [31:0] mshift(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? COEFFS : 32'h0);
  endfunction

  function automatic vec_t mk(input logic r, input logic en, input logic sh, input logic swe,
                              input logic [31:0] wd, input logic cwe,
                              input logic [31:0] el, input logic elk, input logic ec);
    vec_t v;
    v.rst = r; v.en = en; v.sh = sh; v.swe = swe; v.wdata = wd; v.cwe = cwe;
    v.e_lfsr = el; v.e_lock = elk; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] m_lfsr;
    logic        m_lock, m_cnt;
    vec_t        v;

    // The expected values are derived by hand from the polynomial.
    //               rst en sh swe wdata         cwe  lfsr          lk cnt
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,         0,   32'h8000_0057, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,         0,   32'hC000_007C, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'hDEAD_BEEF, 0,   32'hDEAD_BEEF, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,         0,   32'hEF56_DF20, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,         0,   32'h0000_0001, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0,   32'h0000_0001, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,         1,   32'h0000_0001, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,         0,   32'h0000_0001, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h1234_5678, 1,   32'h0000_0001, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0002, 1,   32'h0000_0002, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'hAAAA_5555, 0,   32'hAAAA_5555, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,         1,   32'hAAAA_5555, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,         0,   32'hAAAA_5555, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,         0,   32'hD555_2AFD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0,         0,   32'h0000_0001, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'h0BAD_F00D, 0,   32'h0BAD_F00D, 0, 1));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset.lfsr",   lfsr_o,            SEED0);
    check1("reset.lockup", {31'b0, lockup_o}, 32'h0);
    check1("reset.cntrst", {31'b0, cntrst_o}, 32'h0);

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));

    // With enable low, ten shift requests must leave the state untouched.
    for (int i = 0; i < 10; i++)
      step(mk(0, 0, 1, 0, 32'h0, 0, 32'h0BAD_F00D, 0, 0), $sformatf("hold[%0d]", i));

    // A cpuctrl write pulses cntrst for exactly one cycle.
    step(mk(0, 0, 1, 0, 32'h0, 1, 32'h0BAD_F00D, 0, 1), "cpuctrl.pulse");
    step(mk(0, 0, 1, 0, 32'h0, 0, 32'h0BAD_F00D, 0, 0), "cpuctrl.after");

    // Fault injection: the state becomes zero while enable is low.
    rst = 0; enable_i = 0; shift_i = 0; seed_we_i = 0; cpuctrl_we_i = 0;
    force dut.r_lfsr = 32'h0;
    #1;
    release dut.r_lfsr;
    sb_q.push_back('{lfsr: SEED0, lock: 1'b1, cnt: 1'b0});
    @(posedge clk);
    @(negedge clk);
    compare_out("fault.recover");
    step(mk(0, 0, 0, 0, 32'h0, 0, SEED0, 0, 0), "fault.after");

    // Random traffic checked against a reference model.
    m_lfsr = SEED0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] cand;
      v.rst   = ($urandom_range(0, 63) == 0);
      v.en    = $urandom_range(0, 3) != 0;
      v.sh    = $urandom_range(0, 1);
      v.swe   = ($urandom_range(0, 11) == 0);
      v.wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      v.cwe   = ($urandom_range(0, 11) == 0);
      if (v.rst) begin
        m_lfsr = SEED0; m_lock = 0; m_cnt = 0;
      end else begin
        cand   = v.swe ? v.wdata : ((v.en && v.sh) ? mshift(m_lfsr) : m_lfsr);
        m_lock = (cand == 32'h0);
        m_lfsr = m_lock ? SEED0 : cand;
        m_cnt  = v.swe | v.cwe;
      end
      v.e_lfsr = m_lfsr; v.e_lock = m_lock; v.e_cnt = m_cnt;
      step(v, $sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
